// File: rtl/bp_mc_to_cce_pkg.sv
// Shared types and helpers for the manycore <-> BlackParrot I/O bridges.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bp_mc_bridge_pkg;

  // BlackParrot memory-message geometry used by this slice of the system.
  localparam int paddr_width_gp       = 40;
  localparam int cce_block_width_gp   = 64;
  localparam int mem_payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1 = 3'd0,
    e_mem_msg_size_2 = 3'd1,
    e_mem_msg_size_4 = 3'd2,
    e_mem_msg_size_8 = 3'd3
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [mem_payload_width_gp-1:0] payload;
    bp_mem_msg_size_e                size;
    logic [paddr_width_gp-1:0]       addr;
    bp_cce_mem_cmd_type_e            msg_type;
  } bp_cce_mem_msg_hdr_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_cce_mem_msg_hdr_s           header;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  // Responder FSM states.
  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_send   = 2'd1,
    e_wait   = 2'd2,
    e_return = 2'd3
  } bp_mc_state_e;

  typedef struct packed {
    bp_mem_msg_size_e size;
    logic [1:0]       offset;
    logic             legal;
  } mc_mask_decode_s;

  // Manycore byte mask -> BP access size and byte offset inside the word.
  // Only naturally aligned 1/2/4-byte accesses map onto a single BP command.
  function automatic mc_mask_decode_s mc_mask_decode(input logic [3:0] mask);
    mc_mask_decode_s d;
    d = '{size: e_mem_msg_size_4, offset: 2'd0, legal: 1'b1};
    case (mask)
      4'hF: d = '{size: e_mem_msg_size_4, offset: 2'd0, legal: 1'b1};
      4'h3: d = '{size: e_mem_msg_size_2, offset: 2'd0, legal: 1'b1};
      4'hC: d = '{size: e_mem_msg_size_2, offset: 2'd2, legal: 1'b1};
      4'h1: d = '{size: e_mem_msg_size_1, offset: 2'd0, legal: 1'b1};
      4'h2: d = '{size: e_mem_msg_size_1, offset: 2'd1, legal: 1'b1};
      4'h4: d = '{size: e_mem_msg_size_1, offset: 2'd2, legal: 1'b1};
      4'h8: d = '{size: e_mem_msg_size_1, offset: 2'd3, legal: 1'b1};
      default: d = '{size: e_mem_msg_size_4, offset: 2'd0, legal: 1'b0};
    endcase
    return d;
  endfunction

  // Manycore word address -> BP byte paddr inside the window at base.
  function automatic logic [paddr_width_gp-1:0] mc_addr_to_paddr(
    input logic [paddr_width_gp-1:0] word_addr,
    input logic [paddr_width_gp-1:0] base
  );
    return base | (word_addr << 2);
  endfunction

endpackage

// File: rtl/bp_mc_to_cce_if.sv
// Bundles the manycore endpoint request/response and BP I/O cmd/resp groups.
// Latency: n/a (wires only).
// Backpressure: in_yumi / io_cmd_yumi / io_resp_ready as seen by the bridge.
interface bp_mc_to_cce_if #(
  parameter int mc_data_width_p = 32,
  parameter int mc_addr_width_p = 28
) ();
  import bp_mc_bridge_pkg::*;

  logic                         in_v_i;
  logic [mc_data_width_p-1:0]   in_data_i;
  logic [mc_data_width_p/8-1:0] in_mask_i;
  logic [mc_addr_width_p-1:0]   in_addr_i;
  logic                         in_we_i;
  logic                         in_yumi_o;
  logic [mc_data_width_p-1:0]   returning_data_o;
  logic                         returning_v_o;
  bp_cce_mem_msg_s              io_cmd_o;
  logic                         io_cmd_v_o;
  logic                         io_cmd_yumi_i;
  bp_cce_mem_msg_s              io_resp_i;
  logic                         io_resp_v_i;
  logic                         io_resp_ready_o;
  logic                         error_o;

  // Bridge side.
  modport slave (
    input  in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i,
    output in_yumi_o, returning_data_o, returning_v_o,
    output io_cmd_o, io_cmd_v_o,
    input  io_cmd_yumi_i,
    input  io_resp_i, io_resp_v_i,
    output io_resp_ready_o, error_o
  );

  // Endpoint / BP side.
  modport master (
    output in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i,
    input  in_yumi_o, returning_data_o, returning_v_o,
    input  io_cmd_o, io_cmd_v_o,
    output io_cmd_yumi_i,
    output io_resp_i, io_resp_v_i,
    input  io_resp_ready_o, error_o
  );

endinterface

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous reset to a constant.
// Latency: 1 cycle from en_i/data_i to data_o.
// Backpressure: none; holds value while en_i is low.
module bsg_dff_reset_en #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q, data_d;

  // Load new data only when enabled.
  always_comb begin
    data_d = en_i ? data_i : data_q;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= reset_val_p;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_mc_to_cce.sv
// Turns one manycore remote load/store into one BP uncached I/O cmd and returns the data.
// Latency: 3 cycles best case from in_v_i to returning_v_o; illegal store mask returns after 1.
// Backpressure: one request in flight; io_cmd held until yumi, in_yumi_o only with the response.
module bp_mc_to_cce
  import bp_mc_bridge_pkg::*;
#(
  parameter int                        mc_x_cord_width_p = 4,
  parameter int                        mc_y_cord_width_p = 4,
  parameter int                        mc_data_width_p   = 32,
  parameter int                        mc_addr_width_p   = 28,
  parameter logic [paddr_width_gp-1:0] bp_base_addr_p    = '0
) (
  input logic            clk_i,
  input logic            reset_i,
  bp_mc_to_cce_if.slave  mc_bp
);

  // Coordinates are carried by the endpoint; the responder does not need them.
  localparam int unused_cord_width_lp = mc_x_cord_width_p + mc_y_cord_width_p;

  bp_mc_state_e    state_q, state_d;
  logic            io_cmd_v_q, io_cmd_v_d;
  logic            io_resp_ready_q, io_resp_ready_d;
  logic            returning_v_q, returning_v_d;
  logic            error_q, error_d;

  mc_mask_decode_s dec;
  logic            illegal_store;
  bp_cce_mem_msg_s cmd;
  logic            accept_v;
  logic            latch_v;
  logic [31:0]     latch_dat;
  logic [31:0]     data_r;
  logic            unused_resp;

  // Build the BP command from the request fields, which the endpoint holds until yumi.
  always_comb begin
    dec           = mc_mask_decode(mc_bp.in_mask_i);
    illegal_store = mc_bp.in_we_i & ~dec.legal;
    cmd           = '0;
    cmd.header.addr = mc_addr_to_paddr(paddr_width_gp'(mc_bp.in_addr_i), bp_base_addr_p);
    if (mc_bp.in_we_i) begin
      cmd.header.msg_type  = e_cce_mem_uc_wr;
      cmd.header.size      = dec.size;
      cmd.header.addr[1:0] = cmd.header.addr[1:0] + dec.offset;
      cmd.data[31:0]       = mc_bp.in_data_i >> {dec.offset, 3'b000};
    end else begin
      cmd.header.msg_type  = e_cce_mem_uc_rd;
      cmd.header.size      = e_mem_msg_size_4;
    end
  end

  // Next-state logic; the request is consumed only once its outcome is known.
  always_comb begin
    state_d   = state_q;
    accept_v  = 1'b0;
    latch_v   = 1'b0;
    latch_dat = mc_bp.in_we_i ? 32'd0 : mc_bp.io_resp_i.data[31:0];
    error_d   = error_q;
    case (state_q)
      e_ready: begin
        if (mc_bp.in_v_i) begin
          if (illegal_store) begin
            state_d  = e_return;
            accept_v = 1'b1;
            latch_v  = 1'b1;
            error_d  = 1'b1;
          end else begin
            state_d  = e_send;
          end
        end
      end
      e_send:   if (mc_bp.io_cmd_yumi_i) state_d = e_wait;
      e_wait: begin
        if (mc_bp.io_resp_v_i) begin
          state_d  = e_return;
          accept_v = 1'b1;
          latch_v  = 1'b1;
        end
      end
      e_return: state_d = e_ready;
      default:  state_d = e_ready;
    endcase
    io_cmd_v_d      = (state_d == e_send);
    io_resp_ready_d = (state_d == e_wait);
    returning_v_d   = (state_d == e_return);
  end

  // FSM state plus registered handshake outputs and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= e_ready;
      io_cmd_v_q      <= 1'b0;
      io_resp_ready_q <= 1'b0;
      returning_v_q   <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      io_cmd_v_q      <= io_cmd_v_d;
      io_resp_ready_q <= io_resp_ready_d;
      returning_v_q   <= returning_v_d;
      error_q         <= error_d;
    end
  end

  bsg_dff_reset_en #(
    .width_p     (32),
    .reset_val_p (32'd0)
  ) data_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (latch_v),
    .data_i  (latch_dat),
    .data_o  (data_r)
  );

  assign unused_resp = ^{mc_bp.io_resp_i.header, mc_bp.io_resp_i.data[cce_block_width_gp-1:32]};

  assign mc_bp.in_yumi_o        = accept_v;
  assign mc_bp.io_cmd_v_o       = io_cmd_v_q;
  assign mc_bp.io_cmd_o         = io_cmd_v_q ? cmd : '0;
  assign mc_bp.io_resp_ready_o  = io_resp_ready_q;
  assign mc_bp.returning_v_o    = returning_v_q;
  assign mc_bp.returning_data_o = returning_v_q ? data_r : '0;
  assign mc_bp.error_o          = error_q;

  // The endpoint must hold its request until it is consumed.
  a_in_v_held: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q inside {e_send, e_wait}) |-> mc_bp.in_v_i);

endmodule

// File: tb/tb_bp_mc_to_cce.sv
// Self-checking bench for bp_mc_to_cce: directed cases then randomized requests.
// Latency: n/a.
// Backpressure: exercises held io_cmd and early io_resp offers.
module tb_bp_mc_to_cce;
  import bp_mc_bridge_pkg::*;

  localparam int          AW   = 28;
  localparam logic [39:0] BASE = 40'h80_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic err_exp = 1'b0;

  bp_mc_to_cce_if #(.mc_data_width_p(32), .mc_addr_width_p(AW)) bus ();

  bp_mc_to_cce #(
    .mc_x_cord_width_p (4),
    .mc_y_cord_width_p (4),
    .mc_data_width_p   (32),
    .mc_addr_width_p   (AW),
    .bp_base_addr_p    (BASE)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .mc_bp   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Reference: legality and size from the number of mask bits, offset from the lowest set bit.
  function automatic void model(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                                input logic [3:0] mask, output logic legal, output bp_cce_mem_msg_s cmd);
    int pc;
    int low;
    pc  = 0;
    low = 0;
    for (int b = 3; b >= 0; b--) if (mask[b]) begin pc++; low = b; end
    if (!we) begin
      legal = 1'b1; pc = 4; low = 0;
    end else begin
      legal = (pc == 4) || (pc == 1) || (mask == 4'h3) || (mask == 4'hC);
    end
    cmd = '0;
    cmd.header.msg_type = we ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    cmd.header.size     = (pc == 4) ? e_mem_msg_size_4 : (pc == 2) ? e_mem_msg_size_2 : e_mem_msg_size_1;
    cmd.header.addr     = BASE | ((40'(addr) << 2) + 40'(low));
    if (we) cmd.data = 64'(data >> (8 * low));
  endfunction

  task automatic idle_inputs();
    bus.in_v_i        = 1'b0;
    bus.in_data_i     = '0;
    bus.in_mask_i     = '0;
    bus.in_addr_i     = '0;
    bus.in_we_i       = 1'b0;
    bus.io_cmd_yumi_i = 1'b0;
    bus.io_resp_i     = '0;
    bus.io_resp_v_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, "cmd_v",    bus.io_cmd_v_o, 0);
    check(tag, "cmd",      bus.io_cmd_o, 0);
    check(tag, "resp_rdy", bus.io_resp_ready_o, 0);
    check(tag, "yumi",     bus.in_yumi_o, 0);
    check(tag, "ret_v",    bus.returning_v_o, 0);
    check(tag, "ret_dat",  bus.returning_data_o, 0);
    check(tag, "error",    bus.error_o, 0);
  endtask

  // One full request; entered and left at a negedge with the DUT idle.
  task automatic txn(input string tag, input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                     input logic [3:0] mask, input int cmd_dly, input int resp_dly,
                     input logic [63:0] rdata, input bit early_resp);
    logic            legal;
    bp_cce_mem_msg_s exp_cmd;
    model(we, addr, data, mask, legal, exp_cmd);
    bus.in_v_i    = 1'b1;
    bus.in_we_i   = we;
    bus.in_addr_i = addr;
    bus.in_data_i = data;
    bus.in_mask_i = mask;
    #1;
    if (!legal) begin
      check(tag, "yumi_bad", bus.in_yumi_o, 1);
      check(tag, "cmd_v_bad", bus.io_cmd_v_o, 0);
      err_exp = 1'b1;
      @(negedge clk);
      bus.in_v_i = 1'b0;
      check(tag, "ret_v", bus.returning_v_o, 1);
      check(tag, "ret_dat", bus.returning_data_o, 0);
      check(tag, "cmd_v_ret", bus.io_cmd_v_o, 0);
      check(tag, "yumi_ret", bus.in_yumi_o, 0);
    end else begin
      check(tag, "yumi_c0", bus.in_yumi_o, 0);
      check(tag, "cmd_v_c0", bus.io_cmd_v_o, 0);
      @(negedge clk);
      check(tag, "cmd_v", bus.io_cmd_v_o, 1);
      check(tag, "cmd", bus.io_cmd_o, exp_cmd);
      check(tag, "resp_rdy_send", bus.io_resp_ready_o, 0);
      for (int i = 0; i < cmd_dly; i++) begin
        bus.io_cmd_yumi_i = 1'b0;
        if (early_resp) begin
          bus.io_resp_i      = '0;
          bus.io_resp_i.data = 64'hBAD0_BAD0_BAD0_BAD0;
          bus.io_resp_v_i    = 1'b1;
        end
        @(negedge clk);
        check(tag, "cmd_v_hold", bus.io_cmd_v_o, 1);
        check(tag, "cmd_hold", bus.io_cmd_o, exp_cmd);
        check(tag, "yumi_hold", bus.in_yumi_o, 0);
        check(tag, "resp_rdy_hold", bus.io_resp_ready_o, 0);
      end
      bus.io_resp_v_i   = 1'b0;
      bus.io_cmd_yumi_i = 1'b1;
      @(negedge clk);
      bus.io_cmd_yumi_i = 1'b0;
      check(tag, "cmd_v_wait", bus.io_cmd_v_o, 0);
      check(tag, "resp_rdy_wait", bus.io_resp_ready_o, 1);
      for (int i = 0; i < resp_dly; i++) begin
        check(tag, "yumi_wait", bus.in_yumi_o, 0);
        @(negedge clk);
      end
      bus.io_resp_i      = '0;
      bus.io_resp_i.data = rdata;
      bus.io_resp_v_i    = 1'b1;
      #1;
      check(tag, "yumi", bus.in_yumi_o, 1);
      check(tag, "ret_v_early", bus.returning_v_o, 0);
      @(negedge clk);
      bus.io_resp_v_i = 1'b0;
      bus.in_v_i      = 1'b0;
      check(tag, "ret_v", bus.returning_v_o, 1);
      check(tag, "ret_dat", bus.returning_data_o, we ? 32'd0 : rdata[31:0]);
      check(tag, "yumi_ret", bus.in_yumi_o, 0);
      check(tag, "resp_rdy_ret", bus.io_resp_ready_o, 0);
    end
    check(tag, "error", bus.error_o, err_exp);
    @(negedge clk);
    check(tag, "ret_v_after", bus.returning_v_o, 0);
    check(tag, "error_after", bus.error_o, err_exp);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    txn("load_mid",    1'b0, 28'h100, 32'h0,        4'hF, 0, 1, 64'h1234_5678_DEAD_BEEF, 1'b0);
    txn("store_word",  1'b1, 28'h020, 32'hCAFEF00D, 4'hF, 0, 0, 64'h0, 1'b0);
    txn("byte_store",  1'b1, 28'h010, 32'h00AB0000, 4'h4, 0, 0, 64'h5555, 1'b0);
    txn("half_hi",     1'b1, 28'h033, 32'hBEEF1234, 4'hC, 1, 2, 64'h0, 1'b0);
    txn("byte3",       1'b1, 28'h7FF, 32'h9A000000, 4'h8, 0, 0, 64'h0, 1'b0);
    txn("illegal_5",   1'b1, 28'h044, 32'h11223344, 4'h5, 0, 0, 64'h0, 1'b0);
    txn("illegal_0",   1'b1, 28'h045, 32'h11223344, 4'h0, 0, 0, 64'h0, 1'b0);
    txn("backpressure",1'b0, 28'h0AB, 32'h0,        4'h0, 5, 0, 64'h0000_0000_0BAD_F00D, 1'b1);

    // Reset while waiting for the BP response.
    bus.in_v_i    = 1'b1;
    bus.in_we_i   = 1'b0;
    bus.in_addr_i = 28'h055;
    @(negedge clk);
    bus.io_cmd_yumi_i = 1'b1;
    @(negedge clk);
    bus.io_cmd_yumi_i = 1'b0;
    check("rst_mid", "resp_rdy", bus.io_resp_ready_o, 1);
    check("rst_mid", "error_pre", bus.error_o, 1);
    rst        = 1'b1;
    bus.in_v_i = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    err_exp = 1'b0;
    check_all_zero("rst_mid");
    @(negedge clk);
    txn("post_rst", 1'b0, 28'h200, 32'h0, 4'hF, 0, 0, 64'hFFFF_FFFF_0102_0304, 1'b0);

    for (int n = 0; n < 40; n++) begin
      txn("rand", 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom},
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_mc_to_cce.md
# bp_mc_to_cce

Responder-side bridge that lets manycore tiles issue remote loads and stores into BlackParrot's uncached I/O space. It sits between the `bsg_manycore_endpoint_standard` in_request/out_response groups and BlackParrot's I/O command/response ports. It converts each incoming manycore request into one `e_cce_mem_uc_rd` or `e_cce_mem_uc_wr`, waits for BlackParrot's response, and then returns data to the network. Exactly one request is in flight at a time.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg, BlackParrot configuration; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p and cce_mem_msg_width_lp.
- mc_x_cord_width_p, "inv", manycore X coordinate width.
- mc_y_cord_width_p, "inv", manycore Y coordinate width.
- mc_data_width_p, "inv", manycore data width; must be 32.
- mc_addr_width_p, "inv", manycore word-address width.
- bp_base_addr_p, 0, paddr_width_p-bit base OR'd onto every translated address.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- in_v_i  in  1  endpoint request valid; fields stay stable until in_yumi_o.
- in_data_i  in  mc_data_width_p  store data.
- in_mask_i  in  mc_data_width_p/8  store byte mask.
- in_addr_i  in  mc_addr_width_p  word address.
- in_we_i  in  1  1 = store, 0 = load.
- in_yumi_o  out  1  request consumed.
- returning_data_o  out  mc_data_width_p  response data.
- returning_v_o  out  1  response valid.
- io_cmd_o  out  cce_mem_msg_width_lp  BP command.
- io_cmd_v_o  out  1  command valid.
- io_cmd_yumi_i  in  1  command accepted.
- io_resp_i  in  cce_mem_msg_width_lp  BP response.
- io_resp_v_i  in  1  response valid.
- io_resp_ready_o  out  1  block can take a response.
- error_o  out  1  sticky flag: an unsupported store mask was seen.

## Operation
The block is a four-state FSM: e_ready, e_send, e_wait, e_return.

- **e_ready**: if in_v_i, go to e_send. No outputs are asserted.
- **e_send**: io_cmd_v_o=1. The command is built combinationally from the held in_* fields. Go to e_wait on io_cmd_yumi_i.
- **e_wait**: io_resp_ready_o=1. On io_resp_v_i:
  - latch io_resp_i.data[31:0] into data_r, or latch 0 for a store;
  - assert in_yumi_o in that same cycle;
  - go to e_return.
- **e_return**: returning_v_o=1, returning_data_o=data_r. Go to e_ready.

Command formation:
- Address: header.addr = bp_base_addr_p | (in_addr_i << 2).
- Header payload is '0.
- Loads: msg_type = e_cce_mem_uc_rd, size = e_mem_msg_size_4, word-aligned. The full word is always returned.
- Stores: msg_type = e_cce_mem_uc_wr. The mask is decoded as follows:
  - 4'hF → size_4, offset 0.
  - 4'h3 or 4'hC → size_2, offset 0 or 2.
  - One-hot mask → size_1, offset = bit index.
  - The offset is added to addr[1:0], and data[31:0] = in_data_i >> (8·offset).
- Any other store mask (including 0): no io_cmd is issued. The FSM goes e_ready → e_return directly, asserts in_yumi_o on the transition cycle, returns 0, and sets error_o.

Reset:
- Synchronous reset forces e_ready and clears data_r and error_o.
- After reset, all outputs are 0 until the next in_v_i.
- A request interrupted by reset is dropped.
- error_o clears only on reset.

## Timing
- Best case, stores and loads alike:
  - in_v_i at cycle 0;
  - io_cmd_v_o at cycle 1, with io_cmd_yumi_i in the same cycle;
  - io_resp_v_i at cycle 2, with in_yumi_o at cycle 2;
  - returning_v_o at cycle 3.
- returning_v_o is always exactly one cycle after in_yumi_o.
- returning_v_o is never asserted without a preceding in_yumi_o.
- io_cmd_v_o stays high with a stable io_cmd_o until io_cmd_yumi_i. Its deassertion does not depend on io_cmd_yumi_i combinationally.
- io_resp_ready_o is high only in e_wait. Responses offered in any other state are ignored, not consumed.
- in_v_i dropping before in_yumi_o is a protocol violation; an assertion flags it.
- Throughput is at most one request per 4 cycles. Back-to-back in_v_i is accepted from e_ready immediately after e_return.

## Structure
- A shared package `bp_mc_bridge_pkg` holds:
  - the FSM state enum;
  - the function mapping mc mask → {bp_mem_msg_size_e, offset[1:0], legal};
  - the function mapping mc word address → BP paddr.
- The companion initiator bridge reuses the address function in reverse.
- No sub-module: the FSM and data_r/error_o registers are written inline. data_r uses bsg_dff_reset_en.

## Test plan
- **Load, mid latency**: load at in_addr_i=0x100, BP responds 2 cycles after io_cmd_yumi_i with data 0xDEADBEEF → io_cmd addr=bp_base|0x400, uc_rd, size_4; returning_data_o=0xDEADBEEF one cycle after in_yumi_o.
- **Byte store**: in_mask_i=4'h4, in_data_i=0x00AB0000, in_addr_i=0x10 → uc_wr, addr=0x42, size_1, data[7:0]=0xAB; returning_data_o=0.
- **Illegal mask**: store with in_mask_i=4'h5 → no io_cmd_v_o; in_yumi_o then returning_v_o with 0; error_o=1 and stays set.
- **Back-pressure**: io_cmd_yumi_i held low 5 cycles → io_cmd_o stable throughout, in_yumi_o stays low; io_resp_v_i offered early in e_send is not consumed.
- **Reset mid-request**: reset asserted in e_wait → next cycle all outputs 0, error_o=0; a subsequent load completes normally.
